// File: rtl/sync_config_loader.sv
// Burst loader: reads sync ticks, sync time and the cycle table from BRAM on a SYNC_REQ edge, then commits them.
// Optional macro SYNC_LOADER_ZERO_CHECK_EN replaces zero cycle words with all-ones and raises a sticky CYCLE_ERR.
module sync_config_loader #(
    parameter int          WIDTH      = 13,
    parameter int          DEPTH      = 249,
    parameter int          RD_LATENCY = 2,
    parameter logic [15:0] ADDR_TICKS = 16'h0010,
    parameter logic [15:0] ADDR_TIME  = 16'h0011,
    parameter logic [15:0] ADDR_CYCLE = 16'h0100
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SYNC_REQ,
    output logic             BRAM_EN,
    output logic [15:0]      BRAM_ADDR,
    input  logic [15:0]      BRAM_DOUT,
    output logic [15:0]      ECAT_SYNC_CYCLE_TICKS,
    output logic [63:0]      ECAT_SYNC_TIME,
    output logic             CYCLE_WE,
    output logic [7:0]       CYCLE_IDX,
    output logic [WIDTH-1:0] CYCLE_DATA,
    output logic             SYNC_SET,
    output logic             BUSY,
    output logic             CYCLE_ERR
);

    localparam int         N        = 5 + DEPTH;
    localparam logic [8:0] LAST_SEQ = 9'(N - 1);
    localparam logic [8:0] ALL_SEQ  = 9'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_COMMIT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_req_d;
    logic             r_pending;
    logic [8:0]       r_issue_cnt;
    logic [8:0]       r_ret_cnt;
    logic [15:0]      r_addr;
    logic             w_edge;
    logic             w_start;

    logic             r_dl_vld [RD_LATENCY];
    logic [8:0]       r_dl_seq [RD_LATENCY];
    logic             w_ret_vld;
    logic [8:0]       w_ret_seq;
    logic [1:0]       w_time_lane;
    logic [WIDTH-1:0] w_cycle_raw;
    logic [WIDTH-1:0] w_cycle_val;

    logic [15:0]      r_ticks_sh;
    logic [63:0]      r_time_sh;
    logic [15:0]      r_ticks;
    logic [63:0]      r_time;
    logic             r_cycle_we;
    logic [7:0]       r_cycle_idx;
    logic [WIDTH-1:0] r_cycle_data;

    // Word address for each burst position: ticks, four time words, then the cycle table.
    function automatic logic [15:0] addr_of(input logic [8:0] seq);
        if (seq == 9'd0)
            return ADDR_TICKS;
        else if (seq < 9'd5)
            return ADDR_TIME + 16'(seq - 9'd1);
        else
            return ADDR_CYCLE + 16'(seq - 9'd5);
    endfunction

    assign w_edge  = SYNC_REQ & ~r_req_d;
    assign w_start = (w_next == S_ISSUE) && (r_state != S_ISSUE);

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_edge) w_next = S_ISSUE;
            S_ISSUE:  if (r_issue_cnt == LAST_SEQ) w_next = S_DRAIN;
            S_DRAIN:  if (r_ret_cnt == ALL_SEQ) w_next = S_COMMIT;
            S_COMMIT: w_next = (r_pending || w_edge) ? S_ISSUE : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_req_d     <= 1'b0;
            r_pending   <= 1'b0;
            r_issue_cnt <= '0;
            r_addr      <= '0;
        end else begin
            r_state <= w_next;
            r_req_d <= SYNC_REQ;
            if (w_start)
                r_pending <= 1'b0;
            else if (w_edge && r_state != S_IDLE)
                r_pending <= 1'b1;
            if (w_start) begin
                r_issue_cnt <= '0;
                r_addr      <= addr_of(9'd0);
            end else if (r_state == S_ISSUE && r_issue_cnt != LAST_SEQ) begin
                r_issue_cnt <= r_issue_cnt + 9'd1;
                r_addr      <= addr_of(r_issue_cnt + 9'd1);
            end
        end
    end

    // Return tagging follows BRAM latency only, independent of FSM state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < RD_LATENCY; i++) r_dl_vld[i] <= 1'b0;
        end else begin
            r_dl_vld[0] <= BRAM_EN;
            for (int i = 1; i < RD_LATENCY; i++) r_dl_vld[i] <= r_dl_vld[i-1];
        end
    end

    // NOTE: sequence payload needs no reset; it is ignored whenever its valid bit is clear.
    always_ff @(posedge CLK) begin
        r_dl_seq[0] <= r_issue_cnt;
        for (int i = 1; i < RD_LATENCY; i++) r_dl_seq[i] <= r_dl_seq[i-1];
    end

    assign w_ret_vld   = r_dl_vld[RD_LATENCY-1];
    assign w_ret_seq   = r_dl_seq[RD_LATENCY-1];
    assign w_time_lane = 2'(w_ret_seq - 9'd1);
    assign w_cycle_raw = BRAM_DOUT[WIDTH-1:0];

`ifdef SYNC_LOADER_ZERO_CHECK_EN
    logic w_cycle_zero;
    logic r_cycle_err;

    assign w_cycle_zero = (w_cycle_raw == '0);
    assign w_cycle_val  = w_cycle_zero ? '1 : w_cycle_raw;

    always_ff @(posedge CLK) begin
        if (RST)
            r_cycle_err <= 1'b0;
        else if (w_start)
            r_cycle_err <= 1'b0;
        else if (w_ret_vld && w_ret_seq >= 9'd5 && w_cycle_zero)
            r_cycle_err <= 1'b1;
    end

    assign CYCLE_ERR = r_cycle_err;
`else
    assign w_cycle_val = w_cycle_raw;
    assign CYCLE_ERR   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ret_cnt    <= '0;
            r_ticks_sh   <= '0;
            r_time_sh    <= '0;
            r_ticks      <= '0;
            r_time       <= '0;
            r_cycle_we   <= 1'b0;
            r_cycle_idx  <= '0;
            r_cycle_data <= '0;
        end else begin
            r_cycle_we <= 1'b0;
            if (w_start)
                r_ret_cnt <= '0;
            else if (w_ret_vld)
                r_ret_cnt <= r_ret_cnt + 9'd1;
            if (w_ret_vld) begin
                if (w_ret_seq == 9'd0) begin
                    r_ticks_sh <= BRAM_DOUT;
                end else if (w_ret_seq < 9'd5) begin
                    r_time_sh[{w_time_lane, 4'b0000} +: 16] <= BRAM_DOUT;
                end else begin
                    r_cycle_we   <= 1'b1;
                    r_cycle_idx  <= 8'(w_ret_seq - 9'd5);
                    r_cycle_data <= w_cycle_val;
                end
            end
            // Sync fields update together, on the edge that enters COMMIT.
            if (r_state == S_DRAIN && w_next == S_COMMIT) begin
                r_ticks <= r_ticks_sh;
                r_time  <= r_time_sh;
            end
        end
    end

    assign BRAM_EN               = (r_state == S_ISSUE);
    assign BRAM_ADDR             = r_addr;
    assign ECAT_SYNC_CYCLE_TICKS = r_ticks;
    assign ECAT_SYNC_TIME        = r_time;
    assign CYCLE_WE              = r_cycle_we;
    assign CYCLE_IDX             = r_cycle_idx;
    assign CYCLE_DATA            = r_cycle_data;
    assign SYNC_SET              = (r_state == S_COMMIT);
    assign BUSY                  = (r_state != S_IDLE);

endmodule

// File: tb/tb_sync_config_loader.sv
// Bench for sync_config_loader: three instances (read latency 2, 1, 4) share one BRAM image and request line.
module tb_sync_config_loader;

    localparam int WIDTH = 13;
    localparam int DEPTH = 249;
    localparam int N     = 5 + DEPTH;
    localparam int NI    = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_req = 1'b0;
    logic mon_clr = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [15:0] mem [0:65535];

    logic [NI-1:0]             w_en;
    logic [NI-1:0][15:0]       w_addr;
    logic [NI-1:0][15:0]       w_dout;
    logic [NI-1:0][15:0]       w_ticks;
    logic [NI-1:0][63:0]       w_time;
    logic [NI-1:0]             w_we;
    logic [NI-1:0][7:0]        w_idx;
    logic [NI-1:0][WIDTH-1:0]  w_data;
    logic [NI-1:0]             w_set;
    logic [NI-1:0]             w_busy;
    logic [NI-1:0]             w_err;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = lat_of(g);
        logic [15:0] pipe [L];

        always @(posedge clk) begin
            pipe[0] <= w_en[g] ? mem[w_addr[g]] : 16'hDEAD;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign w_dout[g] = pipe[L-1];

        sync_config_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(L)) u_dut (
            .CLK                  (clk),
            .RST                  (rst),
            .SYNC_REQ             (sync_req),
            .BRAM_EN              (w_en[g]),
            .BRAM_ADDR            (w_addr[g]),
            .BRAM_DOUT            (w_dout[g]),
            .ECAT_SYNC_CYCLE_TICKS(w_ticks[g]),
            .ECAT_SYNC_TIME       (w_time[g]),
            .CYCLE_WE             (w_we[g]),
            .CYCLE_IDX            (w_idx[g]),
            .CYCLE_DATA           (w_data[g]),
            .SYNC_SET             (w_set[g]),
            .BUSY                 (w_busy[g]),
            .CYCLE_ERR            (w_err[g])
        );
    end

    // Observation: BRAM_EN runs, cycle-table writes, SYNC_SET times and committed values.
    int               en_runs [NI];
    int               set_n [NI];
    int               we_n [NI];
    int               run_start [NI][8];
    int               run_len [NI][8];
    int               set_at [NI][8];
    logic [WIDTH-1:0] tbl [NI][256];
    logic             err_seen [NI];
    logic             prev_en [NI];
    logic [15:0]      cap_ticks [NI];
    logic [63:0]      cap_time [NI];

    initial forever begin
        @(negedge clk);
        if (mon_clr) begin
            for (int i = 0; i < NI; i++) begin
                en_runs[i] = 0; set_n[i] = 0; we_n[i] = 0;
                err_seen[i] = 1'b0; prev_en[i] = 1'b0;
                for (int j = 0; j < 256; j++) tbl[i][j] = '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (w_en[i]) begin
                    if (!prev_en[i]) begin
                        if (en_runs[i] < 8) begin
                            run_start[i][en_runs[i]] = cyc;
                            run_len[i][en_runs[i]] = 0;
                        end
                        en_runs[i]++;
                    end
                    if (en_runs[i] <= 8) run_len[i][en_runs[i]-1]++;
                end
                prev_en[i] = w_en[i];
                if (w_we[i]) begin
                    tbl[i][w_idx[i]] = w_data[i];
                    we_n[i]++;
                end
                if (w_set[i]) begin
                    if (set_n[i] < 8) set_at[i][set_n[i]] = cyc;
                    set_n[i]++;
                    cap_ticks[i] = w_ticks[i];
                    cap_time[i] = w_time[i];
                end
                if (w_err[i]) err_seen[i] = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: what the loaded fields must be, straight from the BRAM image.
    function automatic logic [WIDTH-1:0] exp_cycle(input int j);
        logic [15:0] w;
        w = mem[16'h0100 + j];
`ifdef SYNC_LOADER_ZERO_CHECK_EN
        if (w[WIDTH-1:0] == '0) return '1;
`endif
        return w[WIDTH-1:0];
    endfunction

    function automatic logic exp_err();
        logic e;
        e = 1'b0;
`ifdef SYNC_LOADER_ZERO_CHECK_EN
        for (int j = 0; j < DEPTH; j++) begin
            logic [15:0] w;
            w = mem[16'h0100 + j];
            if (w[WIDTH-1:0] == '0) e = 1'b1;
        end
`endif
        return e;
    endfunction

    function automatic logic [63:0] exp_time();
        return {mem[16'h0014], mem[16'h0013], mem[16'h0012], mem[16'h0011]};
    endfunction

    task automatic fill(input bit directed, input int zero_idx, input bit no_zero);
        mem[16'h0010] = directed ? 16'h1234 : 16'($urandom);
        mem[16'h0011] = directed ? 16'hCDEF : 16'($urandom);
        mem[16'h0012] = directed ? 16'h89AB : 16'($urandom);
        mem[16'h0013] = directed ? 16'h4567 : 16'($urandom);
        mem[16'h0014] = directed ? 16'h0123 : 16'($urandom);
        for (int j = 0; j < DEPTH; j++) begin
            mem[16'h0100 + j] = directed ? 16'(j + 1) : 16'($urandom);
            if (no_zero) mem[16'h0100 + j][0] = 1'b1;
        end
        if (zero_idx >= 0) mem[16'h0100 + zero_idx] = 16'h0000;
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1 mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic edge_req();
        @(posedge clk);
        #1 sync_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 sync_req = 1'b0;
    endtask

    task automatic wait_loads(input int target, input string tag);
        int  t;
        bit  done;
        t = 0;
        done = 1'b0;
        while (!done && t < 3000) begin
            @(posedge clk);
            t++;
            done = 1'b1;
            for (int i = 0; i < NI; i++) if (set_n[i] < target) done = 1'b0;
        end
        check({tag, "_timeout"}, 64'(done), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_load(input string tag, input int k);
        for (int i = 0; i < NI; i++) begin
            string s;
            int    mism;
            s = $sformatf("%s_L%0d", tag, lat_of(i));
            check({s, "_en_run"}, 64'(run_len[i][k]), 64'(N));
            check({s, "_set_lat"}, 64'(set_at[i][k] - run_start[i][k]), 64'(N + lat_of(i) + 1));
            check({s, "_ticks"}, 64'(cap_ticks[i]), 64'(mem[16'h0010]));
            check({s, "_time"}, cap_time[i], exp_time());
            mism = 0;
            for (int j = 0; j < DEPTH; j++) if (tbl[i][j] !== exp_cycle(j)) mism++;
            check({s, "_tbl_mism"}, 64'(mism), 64'd0);
            check({s, "_err"}, 64'(err_seen[i]), 64'(exp_err()));
            check({s, "_busy_end"}, 64'(w_busy[i]), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: nothing may move.
        clear_mon();
        repeat (100) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("idle_en_L%0d", lat_of(i)), 64'(en_runs[i]), 64'd0);
            check($sformatf("idle_we_L%0d", lat_of(i)), 64'(we_n[i]), 64'd0);
            check($sformatf("idle_set_L%0d", lat_of(i)), 64'(set_n[i]), 64'd0);
            check($sformatf("idle_busy_L%0d", lat_of(i)), 64'(w_busy[i]), 64'd0);
            check($sformatf("idle_ticks_L%0d", lat_of(i)), 64'(w_ticks[i]), 64'd0);
            check($sformatf("idle_time_L%0d", lat_of(i)), w_time[i], 64'd0);
        end

        // Directed load with known pattern.
        fill(1'b1, -1, 1'b0);
        clear_mon();
        edge_req();
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check($sformatf("dir_busy_L%0d", lat_of(i)), 64'(w_busy[i]), 64'd1);
        wait_loads(1, "dir");
        check_load("dir", 0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("dir_last_L%0d", lat_of(i)), 64'(tbl[i][248]), 64'd249);
            check($sformatf("dir_we_n_L%0d", lat_of(i)), 64'(we_n[i]), 64'(DEPTH));
            check($sformatf("dir_runs_L%0d", lat_of(i)), 64'(en_runs[i]), 64'd1);
            check($sformatf("dir_out_ticks_L%0d", lat_of(i)), 64'(w_ticks[i]), 64'h1234);
            check($sformatf("dir_out_time_L%0d", lat_of(i)), w_time[i], 64'h0123_4567_89AB_CDEF);
        end

        // Two extra edges during the burst: exactly one pending load, back-to-back.
        fill(1'b0, -1, 1'b0);
        clear_mon();
        edge_req();
        repeat (46) @(posedge clk);
        #1 sync_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 sync_req = 1'b0;
        repeat (6) @(posedge clk);
        #1 sync_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 sync_req = 1'b0;
        wait_loads(2, "pend");
        repeat (600) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("pend_sets_L%0d", lat_of(i)), 64'(set_n[i]), 64'd2);
            check($sformatf("pend_runs_L%0d", lat_of(i)), 64'(en_runs[i]), 64'd2);
            check($sformatf("pend_b2b_L%0d", lat_of(i)), 64'(run_start[i][1]), 64'(set_at[i][0] + 1));
            check($sformatf("pend_run0_L%0d", lat_of(i)), 64'(run_len[i][0]), 64'(N));
        end
        check_load("pend", 1);

        // Reset in the middle of a burst.
        fill(1'b0, -1, 1'b0);
        clear_mon();
        edge_req();
        repeat (96) @(posedge clk);
        #1 rst = 1'b1;
        clear_mon();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_we_L%0d", lat_of(i)), 64'(we_n[i]), 64'd0);
            check($sformatf("rst_set_L%0d", lat_of(i)), 64'(set_n[i]), 64'd0);
            check($sformatf("rst_en_L%0d", lat_of(i)), 64'(en_runs[i]), 64'd0);
            check($sformatf("rst_ticks_L%0d", lat_of(i)), 64'(w_ticks[i]), 64'd0);
            check($sformatf("rst_time_L%0d", lat_of(i)), w_time[i], 64'd0);
        end
        clear_mon();
        edge_req();
        wait_loads(1, "post_rst");
        check_load("post_rst", 0);

        // Zero cycle word at index 7, then a clean load clears the flag.
        fill(1'b0, 7, 1'b1);
        clear_mon();
        edge_req();
        wait_loads(1, "zero");
        check_load("zero", 0);
        for (int i = 0; i < NI; i++) begin
`ifdef SYNC_LOADER_ZERO_CHECK_EN
            check($sformatf("zero_idx7_L%0d", lat_of(i)), 64'(tbl[i][7]), 64'h1FFF);
            check($sformatf("zero_flag_L%0d", lat_of(i)), 64'(w_err[i]), 64'd1);
`else
            check($sformatf("zero_idx7_L%0d", lat_of(i)), 64'(tbl[i][7]), 64'h0000);
            check($sformatf("zero_flag_L%0d", lat_of(i)), 64'(w_err[i]), 64'd0);
`endif
        end
        fill(1'b0, -1, 1'b1);
        clear_mon();
        edge_req();
        wait_loads(1, "clean");
        check_load("clean", 0);
        for (int i = 0; i < NI; i++) check($sformatf("clean_flag_L%0d", lat_of(i)), 64'(w_err[i]), 64'd0);

        // Randomized loads with random idle gaps.
        for (int r = 0; r < 3; r++) begin
            fill(1'b0, -1, 1'b0);
            clear_mon();
            repeat ($urandom_range(1, 20)) @(posedge clk);
            edge_req();
            wait_loads(1, $sformatf("rnd%0d", r));
            check_load($sformatf("rnd%0d", r), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
